// File: rtl/bist_pkg.sv
// Shared types and step functions for the scan-BIST controller.
// Step functions work on MAX_W-wide values; callers cast to their own widths.
package bist_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INIT,
      S_SHIFT,
      S_CAPTURE,
      S_UNLOAD,
      S_COMPARE,
      S_DONE
   } state_t;

   localparam int MAX_W = 64;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic logic [MAX_W-1:0] lfsr_next(
      input logic [MAX_W-1:0] value,
      input logic [MAX_W-1:0] poly
   );
      return (value >> 1) ^ (value[0] ? poly : '0);
   endfunction

   function automatic logic [MAX_W-1:0] misr_next(
      input logic [MAX_W-1:0] value,
      input logic [MAX_W-1:0] poly,
      input logic [MAX_W-1:0] data
   );
      return ((value >> 1) ^ (value[0] ? poly : '0)) ^ data;
   endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register; chain i feeds bit i.
module bist_misr
   import bist_pkg::*;
#(
   parameter int                MISR_W    = 16,
   parameter int                N_CHAINS  = 2,
   parameter logic [MISR_W-1:0] MISR_POLY = 16'hB400
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                clear,
   input  logic                enable,
   input  logic [N_CHAINS-1:0] data,
   output logic [MISR_W-1:0]   signature
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         signature <= '0;
      end else if (clear) begin
         signature <= '0;
      end else if (enable) begin
         signature <= MISR_W'(misr_next(MAX_W'(signature),
                                        MAX_W'(MISR_POLY),
                                        MAX_W'(data)));
      end
   end

endmodule

// File: rtl/bist_scan_controller_param.sv
// Scan-BIST controller: LFSR-fed chains, capture strobes, MISR
// compaction and golden-signature compare.
module bist_scan_controller_param
   import bist_pkg::*;
#(
   parameter int                N_CHAINS   = 2,
   parameter int                CHAIN_LEN  = 8,
   parameter int                N_PATTERNS = 4,
   parameter int                LFSR_W     = 16,
   parameter logic [LFSR_W-1:0] LFSR_POLY  = 16'hB400,
   parameter logic [LFSR_W-1:0] LFSR_SEED  = 16'hACE1,
   parameter int                MISR_W     = 16,
   parameter logic [MISR_W-1:0] MISR_POLY  = 16'hB400,
   parameter logic [MISR_W-1:0] GOLDEN_SIG = 16'h0000,
   localparam int               PC_W       = clog2(N_PATTERNS + 1),
   localparam int               CNT_W      = (CHAIN_LEN > 1) ? clog2(CHAIN_LEN) : 1
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                bist_start,
   input  logic                bist_abort,
   input  logic [N_CHAINS-1:0] cut_scan_out,
   output logic [N_CHAINS-1:0] cut_scan_in,
   output logic                cut_scan_en,
   output logic                cut_capture,
   output logic                bist_busy,
   output logic                bist_end,
   output logic                pass_nfail,
   output logic [MISR_W-1:0]   misr_signature,
   output logic [PC_W-1:0]     pattern_count
);

   if (N_CHAINS > MISR_W || N_CHAINS > LFSR_W) begin : g_bad_width
      $error("N_CHAINS must not exceed LFSR_W or MISR_W");
   end

   state_t             state;
   state_t             state_next;
   logic [LFSR_W-1:0]  lfsr;
   logic [CNT_W-1:0]   shift_cnt;
   logic               last_shift;
   logic               last_pattern;
   logic               abort_hit;
   logic               misr_clear;
   logic               misr_enable;

   assign last_shift   = (shift_cnt == CNT_W'(CHAIN_LEN - 1));
   assign last_pattern = (pattern_count == PC_W'(N_PATTERNS - 1));
   assign abort_hit    = bist_abort && bist_busy;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      unique case (state)
         S_IDLE:    if (bist_start) state_next = S_INIT;
         S_INIT:    state_next = S_SHIFT;
         S_SHIFT:   if (last_shift) state_next = S_CAPTURE;
         S_CAPTURE: state_next = last_pattern ? S_UNLOAD : S_SHIFT;
         S_UNLOAD:  if (last_shift) state_next = S_COMPARE;
         S_COMPARE: state_next = S_DONE;
         S_DONE:    if (bist_start) state_next = S_INIT;
         default:   state_next = S_IDLE;
      endcase
      if (abort_hit) state_next = S_IDLE;
   end

   always_comb begin
      cut_scan_in = '0;
      cut_scan_en = 1'b0;
      cut_capture = 1'b0;
      bist_busy   = 1'b0;
      bist_end    = 1'b0;
      unique case (state)
         S_INIT:    bist_busy = 1'b1;
         S_SHIFT: begin
            bist_busy   = 1'b1;
            cut_scan_en = 1'b1;
            cut_scan_in = lfsr[N_CHAINS-1:0];
         end
         S_CAPTURE: begin
            bist_busy   = 1'b1;
            cut_capture = 1'b1;
         end
         S_UNLOAD: begin
            bist_busy   = 1'b1;
            cut_scan_en = 1'b1;
         end
         S_COMPARE: bist_busy = 1'b1;
         S_DONE:    bist_end  = 1'b1;
         default:   ;
      endcase
   end

   // Abort leaves LFSR and MISR untouched so they can be inspected.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         lfsr          <= LFSR_SEED;
         shift_cnt     <= '0;
         pattern_count <= '0;
         pass_nfail    <= 1'b0;
      end else if (abort_hit) begin
         shift_cnt     <= '0;
         pattern_count <= '0;
         pass_nfail    <= 1'b0;
      end else begin
         unique case (state)
            S_INIT: begin
               lfsr          <= LFSR_SEED;
               shift_cnt     <= '0;
               pattern_count <= '0;
               pass_nfail    <= 1'b0;
            end
            S_SHIFT: begin
               lfsr      <= LFSR_W'(lfsr_next(MAX_W'(lfsr), MAX_W'(LFSR_POLY)));
               shift_cnt <= last_shift ? '0 : shift_cnt + CNT_W'(1);
            end
            S_CAPTURE: pattern_count <= pattern_count + PC_W'(1);
            S_UNLOAD:  shift_cnt <= last_shift ? '0 : shift_cnt + CNT_W'(1);
            S_COMPARE: pass_nfail <= (misr_signature == GOLDEN_SIG);
            S_DONE:    if (bist_start) pass_nfail <= 1'b0;
            default:   ;
         endcase
      end
   end

   // The first load's unload carries reset/garbage data and is skipped.
   assign misr_clear  = (state == S_INIT);
   assign misr_enable = !abort_hit &&
                        (((state == S_SHIFT) && (pattern_count != '0)) ||
                         (state == S_UNLOAD));

   bist_misr #(
      .MISR_W    (MISR_W),
      .N_CHAINS  (N_CHAINS),
      .MISR_POLY (MISR_POLY)
   ) u_misr (
      .clock     (clock),
      .reset     (reset),
      .clear     (misr_clear),
      .enable    (misr_enable),
      .data      (cut_scan_out),
      .signature (misr_signature)
   );

endmodule

// File: tb/tb_bist_scan_controller_param.sv
// Randomised bench for the scan-BIST controller with a behavioural
// signature model and a loopback CUT.
module tb_bist_scan_controller_param;

   localparam int NC      = 2;
   localparam int CL      = 8;
   localparam int NP      = 4;
   localparam int RUN_LEN = 1 + NP * (CL + 1) + CL + 1;
   localparam int QLEN    = RUN_LEN + 24;

   logic          clock = 1'b0;
   logic          reset = 1'b0;
   logic          bist_start = 1'b0;
   logic          bist_abort = 1'b0;
   logic [NC-1:0] cut_scan_out;
   logic [NC-1:0] cut_scan_in;
   logic          cut_scan_en;
   logic          cut_capture;
   logic          bist_busy;
   logic          bist_end;
   logic          pass_nfail;
   logic [15:0]   misr_signature;
   logic [2:0]    pattern_count;

   int            errors = 0;
   int            checks = 0;

   int            mode = 0;
   logic [NC-1:0] const_val = '0;
   logic [NC-1:0] rand_val = '0;
   logic [NC-1:0] chain [CL];
   logic [NC-1:0] rq [QLEN];
   logic [NC-1:0] exp_ld [NP*CL];

   logic [15:0]   sig_a;
   logic [15:0]   sig_b;
   logic [15:0]   sig_c;

   always #5 clock = ~clock;

   bist_scan_controller_param dut (
      .clock          (clock),
      .reset          (reset),
      .bist_start     (bist_start),
      .bist_abort     (bist_abort),
      .cut_scan_out   (cut_scan_out),
      .cut_scan_in    (cut_scan_in),
      .cut_scan_en    (cut_scan_en),
      .cut_capture    (cut_capture),
      .bist_busy      (bist_busy),
      .bist_end       (bist_end),
      .pass_nfail     (pass_nfail),
      .misr_signature (misr_signature),
      .pattern_count  (pattern_count)
   );

   always_comb begin
      cut_scan_out = chain[CL-1];
      if (mode == 0)      cut_scan_out = const_val;
      else if (mode == 1) cut_scan_out = rand_val;
   end

   // Loopback CUT: chains shift when enabled, capture inverts every flop.
   always @(posedge clock) begin
      if (cut_capture) begin
         for (int i = 0; i < CL; i++) chain[i] <= ~chain[i];
      end else if (cut_scan_en) begin
         chain[0] <= cut_scan_in;
         for (int i = 1; i < CL; i++) chain[i] <= chain[i-1];
      end
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [15:0] lstep(input logic [15:0] x);
      return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [15:0] mstep(input logic [15:0] m,
                                         input logic [NC-1:0] d);
      return ((m >> 1) ^ (m[0] ? 16'hB400 : 16'h0000)) ^ {14'b0, d};
   endfunction

   // Pattern p (0-based) shifts on cycles 1+p*(CL+1)+j after start;
   // unload follows the last capture. Loads from pattern p-1 come back
   // inverted while pattern p is shifted in.
   task automatic model(output logic [15:0] sig);
      logic [15:0]   l;
      logic [NC-1:0] d;
      int            t;
      l = 16'hACE1;
      for (int k = 0; k < NP * CL; k++) begin
         exp_ld[k] = l[NC-1:0];
         l = lstep(l);
      end
      sig = 16'h0000;
      for (int p = 1; p <= NP; p++) begin
         for (int j = 0; j < CL; j++) begin
            t = 1 + p * (CL + 1) + j;
            if (mode == 0)      d = const_val;
            else if (mode == 1) d = rq[t];
            else                d = ~exp_ld[(p-1)*CL + j];
            sig = mstep(sig, d);
         end
      end
   endtask

   task automatic run(input string tag, input bit poke,
                      output logic [15:0] sig_out);
      logic [15:0] want;
      int          caps;
      int          end_t;
      int          inerr;
      model(want);
      bist_start = 1'b1;
      tick();
      bist_start = 1'b0;
      caps  = 0;
      end_t = -1;
      inerr = 0;
      for (int t = 0; t < QLEN; t++) begin
         if (bist_end) begin
            end_t = t;
            break;
         end
         rand_val = rq[t];
         if (t >= 1 && t <= CL && cut_scan_in !== exp_ld[t-1]) inerr++;
         if (cut_capture) caps++;
         if (poke) bist_start = (t == 5 || t == 14 || t == 40);
         tick();
      end
      bist_start = 1'b0;
      check({tag, ".latency"}, end_t, RUN_LEN);
      check({tag, ".captures"}, caps, NP);
      check({tag, ".scan_in"}, inerr, 0);
      check({tag, ".sig"}, misr_signature, want);
      check({tag, ".pass"}, pass_nfail, (want == 16'h0000));
      check({tag, ".busy"}, bist_busy, 0);
      check({tag, ".pcount"}, pattern_count, NP);
      sig_out = misr_signature;
   endtask

   initial begin
      for (int i = 0; i < CL; i++) chain[i] = '0;
      for (int i = 0; i < QLEN; i++) rq[i] = NC'($urandom);

      reset = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      check("rst.busy", bist_busy, 0);
      check("rst.end", bist_end, 0);
      check("rst.pass", pass_nfail, 0);
      check("rst.scan_en", cut_scan_en, 0);
      check("rst.capture", cut_capture, 0);
      check("rst.scan_in", cut_scan_in, 0);
      check("rst.sig", misr_signature, 0);
      check("rst.pcount", pattern_count, 0);

      mode = 0;
      const_val = 2'b00;
      run("zero", 1'b0, sig_a);
      check("zero.sig_is_0", sig_a, 16'h0000);
      check("zero.pass_is_1", pass_nfail, 1);

      const_val = 2'b01;
      run("ones", 1'b0, sig_a);

      for (int r = 0; r < 3; r++) begin
         mode = 0;
         const_val = NC'($urandom_range(1, 3));
         run($sformatf("const%0d", r), 1'b0, sig_a);
         mode = 1;
         for (int i = 0; i < QLEN; i++) rq[i] = NC'($urandom);
         run($sformatf("rand%0d", r), 1'b1, sig_a);
      end

      mode = 2;
      run("loop", 1'b0, sig_a);

      // Abort mid-run with a simultaneous start; abort must win.
      bist_start = 1'b1;
      tick();
      bist_start = 1'b0;
      repeat (20) tick();
      bist_abort = 1'b1;
      bist_start = 1'b1;
      tick();
      bist_abort = 1'b0;
      bist_start = 1'b0;
      check("abort.busy", bist_busy, 0);
      check("abort.end", bist_end, 0);
      check("abort.pass", pass_nfail, 0);
      check("abort.scan_en", cut_scan_en, 0);
      check("abort.pcount", pattern_count, 0);
      tick();
      check("abort.stays_idle", bist_busy, 0);

      run("after_abort", 1'b0, sig_b);
      check("after_abort.same_sig", sig_b, sig_a);
      run("rerun", 1'b1, sig_c);
      check("rerun.same_sig", sig_c, sig_a);

      bist_abort = 1'b1;
      tick();
      bist_abort = 1'b0;
      check("done_abort.end", bist_end, 1);
      check("done_abort.sig", misr_signature, sig_a);

      // Reset while unloading clears everything without a clock edge.
      bist_start = 1'b1;
      tick();
      bist_start = 1'b0;
      repeat (40) tick();
      check("unload.scan_en", cut_scan_en, 1);
      check("unload.busy", bist_busy, 1);
      reset = 1'b0;
      #1;
      check("midrst.busy", bist_busy, 0);
      check("midrst.scan_en", cut_scan_en, 0);
      check("midrst.sig", misr_signature, 0);
      check("midrst.pcount", pattern_count, 0);
      check("midrst.end", bist_end, 0);
      tick();
      reset = 1'b1;
      tick();
      run("post_rst", 1'b0, sig_b);
      check("post_rst.same_sig", sig_b, sig_a);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
